// File: rtl/conv_bram_sr_img_loader.sv
// Raster-order frame loader for the row-striped image BRAMs of the shift-register
// convolution controller; hands each loaded frame over with a val/rdy start handshake.
module conv_bram_sr_img_loader #(
    parameter int DATA_WIDTH                    = 12,
    parameter int IMG_W                         = 16,
    parameter int IMG_H                         = 16,
    parameter int IMG_D                         = 4,
    parameter int FILTER_L                      = 3,
    parameter int IMG_W_ADDR_WIDTH              = $clog2(IMG_W),
    parameter int IMG_H_ADDR_WIDTH              = $clog2(IMG_H),
    parameter int STRIPE_ROWS                   = (IMG_H + FILTER_L - 1) / FILTER_L,
    parameter int IMG_RAM_ADDR_WIDTH_PER_STRIPE = $clog2(IMG_W * STRIPE_ROWS)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     pix_val,
    output logic                                     pix_rdy,
    input  logic [IMG_D*DATA_WIDTH-1:0]              pix_data,
    output logic [FILTER_L-1:0]                      img_wren,
    output logic [IMG_RAM_ADDR_WIDTH_PER_STRIPE-1:0] img_wraddr,
    output logic [IMG_D*DATA_WIDTH-1:0]              img_wrdata,
    output logic                                     conv_val,
    input  logic                                     conv_rdy,
    input  logic                                     conv_last_val,
    output logic                                     frame_loaded
);

    localparam int SEL_WIDTH = (FILTER_L > 1) ? $clog2(FILTER_L) : 1;
    localparam int AW        = IMG_RAM_ADDR_WIDTH_PER_STRIPE;

    localparam logic [1:0] LOAD    = 2'd0;
    localparam logic [1:0] HANDOFF = 2'd1;
    localparam logic [1:0] COMPUTE = 2'd2;

    localparam logic [IMG_W_ADDR_WIDTH-1:0] W_LAST      = IMG_W_ADDR_WIDTH'(IMG_W - 1);
    localparam logic [IMG_W_ADDR_WIDTH-1:0] W_ONE       = IMG_W_ADDR_WIDTH'(1);
    localparam logic [IMG_H_ADDR_WIDTH-1:0] H_LAST      = IMG_H_ADDR_WIDTH'(IMG_H - 1);
    localparam logic [IMG_H_ADDR_WIDTH-1:0] H_ONE       = IMG_H_ADDR_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0]        STRIPE_LAST = SEL_WIDTH'(FILTER_L - 1);
    localparam logic [SEL_WIDTH-1:0]        STRIPE_ONE  = SEL_WIDTH'(1);
    localparam logic [AW-1:0]               ROW_STEP    = AW'(IMG_W);
    localparam logic [FILTER_L-1:0]         BANK_ZERO   = FILTER_L'(1);

    logic [1:0]                  state;
    logic [IMG_W_ADDR_WIDTH-1:0] w_cnt;
    logic [IMG_H_ADDR_WIDTH-1:0] h_cnt;
    logic [SEL_WIDTH-1:0]        stripe_sel;
    logic [AW-1:0]               row_base;
    logic                        accept;
    logic                        last_pix;

    assign pix_rdy      = (state == LOAD);
    assign conv_val     = (state == HANDOFF);
    assign frame_loaded = conv_val && conv_rdy;
    assign accept       = pix_val && pix_rdy;
    assign last_pix     = (w_cnt == W_LAST) && (h_cnt == H_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            case (state)
                LOAD:    if (accept && last_pix) state <= HANDOFF;
                HANDOFF: if (conv_rdy)           state <= COMPUTE;
                COMPUTE: if (conv_last_val)      state <= LOAD;
                default:                         state <= LOAD;
            endcase
        end
    end

    // Stripe bank and per-stripe address are tracked incrementally so no divide or
    // multiply by IMG_W / FILTER_L is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_cnt      <= '0;
            h_cnt      <= '0;
            stripe_sel <= '0;
            row_base   <= '0;
        end else if (accept) begin
            if (w_cnt != W_LAST) begin
                w_cnt <= w_cnt + W_ONE;
            end else if (h_cnt == H_LAST) begin
                w_cnt      <= '0;
                h_cnt      <= '0;
                stripe_sel <= '0;
                row_base   <= '0;
            end else begin
                w_cnt <= '0;
                h_cnt <= h_cnt + H_ONE;
                if (stripe_sel == STRIPE_LAST) begin
                    stripe_sel <= '0;
                    row_base   <= row_base + ROW_STEP;
                end else begin
                    stripe_sel <= stripe_sel + STRIPE_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            img_wren   <= '0;
            img_wraddr <= '0;
            img_wrdata <= '0;
        end else begin
            img_wren <= '0;
            if (accept) begin
                img_wren   <= BANK_ZERO << stripe_sel;
                img_wraddr <= row_base + AW'(w_cnt);
                img_wrdata <= pix_data;
            end
        end
    end

endmodule

// File: tb/tb_conv_bram_sr_img_loader.sv
// Scoreboard bench for conv_bram_sr_img_loader: expected BRAM writes come from
// pixel-index arithmetic (bank = h mod L, addr = (h / L) * W + w).
module tb_conv_bram_sr_img_loader;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 5;
    localparam int D  = 2;
    localparam int FL = 3;
    localparam int AW = 3;

    typedef struct {
        logic [FL-1:0]   wren;
        logic [AW-1:0]   addr;
        logic [D*DW-1:0] data;
    } wr_t;

    logic            clk;
    logic            reset;
    logic            pix_val;
    logic            pix_rdy;
    logic [D*DW-1:0] pix_data;
    logic [FL-1:0]   img_wren;
    logic [AW-1:0]   img_wraddr;
    logic [D*DW-1:0] img_wrdata;
    logic            conv_val;
    logic            conv_rdy;
    logic            conv_last_val;
    logic            frame_loaded;

    int  checks      = 0;
    int  failures    = 0;
    int  writes_seen = 0;
    int  pix_idx     = 0;
    wr_t exp_q[$];

    conv_bram_sr_img_loader #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .IMG_D(D), .FILTER_L(FL)
    ) dut (
        .clk(clk), .reset(reset),
        .pix_val(pix_val), .pix_rdy(pix_rdy), .pix_data(pix_data),
        .img_wren(img_wren), .img_wraddr(img_wraddr), .img_wrdata(img_wrdata),
        .conv_val(conv_val), .conv_rdy(conv_rdy), .conv_last_val(conv_last_val),
        .frame_loaded(frame_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer the next raster pixel until it is accepted; the expected write is
    // queued at the moment of acceptance.
    task automatic applyStimulus(input bit use_gaps, input bit noise);
        int  budget = 200;
        bit  done   = 1'b0;
        int  h, w;
        wr_t e;
        while (!done) begin
            conv_last_val = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            pix_val       = use_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            pix_data      = {8'($urandom), 8'(pix_idx)};
            if (pix_val && pix_rdy) begin
                h      = pix_idx / W;
                w      = pix_idx % W;
                e.wren = FL'(1 << (h % FL));
                e.addr = AW'((h / FL) * W + w);
                e.data = pix_data;
                exp_q.push_back(e);
                pix_idx = (pix_idx + 1) % (W * H);
                done    = 1'b1;
            end
            @(negedge clk);
            budget--;
            if (!done && budget == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL pix_accept_timeout: got no acceptance expected pix_rdy=1");
                done = 1'b1;
            end
        end
        pix_val       = 1'b0;
        conv_last_val = 1'b0;
    endtask

    task automatic finishFrame(input int rdy_delay, input int compute_cycles, input int writes_before);
        #1;
        checkOutput("handoff_conv_val", 32'(conv_val), 32'd1);
        checkOutput("handoff_pix_rdy", 32'(pix_rdy), 32'd0);
        for (int i = 0; i < rdy_delay; i++) begin
            conv_rdy = 1'b0;
            #1;
            checkOutput("hold_conv_val", 32'(conv_val), 32'd1);
            checkOutput("hold_pix_rdy", 32'(pix_rdy), 32'd0);
            checkOutput("hold_frame_loaded", 32'(frame_loaded), 32'd0);
            @(negedge clk);
        end
        conv_rdy = 1'b1;
        #1;
        checkOutput("frame_loaded_pulse", 32'(frame_loaded), 32'd1);
        @(negedge clk);
        conv_rdy = 1'b0;
        #1;
        checkOutput("compute_frame_loaded", 32'(frame_loaded), 32'd0);
        checkOutput("compute_conv_val", 32'(conv_val), 32'd0);
        checkOutput("frame_writes", 32'(writes_seen - writes_before), 32'(W * H));
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < compute_cycles; i++) begin
            pix_val  = 1'b1;
            pix_data = 16'($urandom);
            #1;
            checkOutput("compute_pix_rdy", 32'(pix_rdy), 32'd0);
            @(negedge clk);
        end
        pix_val       = 1'b0;
        conv_last_val = 1'b1;
        @(negedge clk);
        conv_last_val = 1'b0;
        #1;
        checkOutput("resume_pix_rdy", 32'(pix_rdy), 32'd1);
    endtask

    // Monitor: every asserted write enable must match the oldest queued write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (img_wren !== '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write: got wren=%b addr=%0d expected no write", img_wren, img_wraddr);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_wren", 32'(img_wren), 32'(e.wren));
                    checkOutput("wr_addr", 32'(img_wraddr), 32'(e.addr));
                    checkOutput("wr_data", 32'(img_wrdata), 32'(e.data));
                    writes_seen++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wb;
        reset         = 1'b1;
        pix_val       = 1'b0;
        pix_data      = '0;
        conv_rdy      = 1'b0;
        conv_last_val = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_wren", 32'(img_wren), 32'd0);
        checkOutput("rst_wraddr", 32'(img_wraddr), 32'd0);
        checkOutput("rst_wrdata", 32'(img_wrdata), 32'd0);
        checkOutput("rst_conv_val", 32'(conv_val), 32'd0);
        checkOutput("rst_frame_loaded", 32'(frame_loaded), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_pix_rdy", 32'(pix_rdy), 32'd1);
        @(negedge clk);

        $display("[TB] frame 1: continuous stream, immediate start");
        wb = writes_seen;
        repeat (W * H) applyStimulus(1'b0, 1'b0);
        finishFrame(0, 3, wb);

        $display("[TB] frame 2: random gaps, conv_last_val noise, delayed conv_rdy");
        @(negedge clk);
        wb = writes_seen;
        repeat (W * H) applyStimulus(1'b1, 1'b1);
        finishFrame(7, 10, wb);

        $display("[TB] frame 3: reset after 9 pixels, then full frame");
        @(negedge clk);
        repeat (9) applyStimulus(1'b1, 1'b0);
        reset   = 1'b1;
        pix_val = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        pix_idx = 0;
        #1;
        checkOutput("midrst_wren", 32'(img_wren), 32'd0);
        checkOutput("midrst_queue", 32'(exp_q.size()), 32'd0);
        checkOutput("midrst_pix_rdy", 32'(pix_rdy), 32'd1);
        checkOutput("midrst_conv_val", 32'(conv_val), 32'd0);
        @(negedge clk);
        wb = writes_seen;
        repeat (W * H) applyStimulus(1'b0, 1'b1);
        finishFrame(2, 2, wb);

        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_bram_sr_img_loader.md
# conv_bram_sr_img_loader

Writes one image frame, streamed in raster order, into the row-striped image BRAMs read by the striped shift-register convolution controller. Image row h lands in stripe bank h mod FILTER_L at per-stripe address (h / FILTER_L) * IMG_W + w, with all IMG_D channel BRAMs written in parallel. After the last pixel is written, the loader hands the frame to the convolution controller with a val/rdy start handshake. It then blocks new pixels until that controller reports completion.

## Interface
- DATA_WIDTH, 12: bits per channel sample.
- IMG_W, 16: image width.
- IMG_H, 16: image height.
- IMG_D, 4: channels; one BRAM per channel per stripe.
- FILTER_L, 3: filter length; equals the number of stripe banks.
- IMG_W_ADDR_WIDTH, $clog2(IMG_W): width of the w counter (derived, not set manually).
- IMG_H_ADDR_WIDTH, $clog2(IMG_H): width of the h counter (derived).
- STRIPE_ROWS, (IMG_H+FILTER_L-1)/FILTER_L: rows per stripe bank (derived).
- IMG_RAM_ADDR_WIDTH_PER_STRIPE, $clog2(IMG_W*STRIPE_ROWS): per-stripe address width (derived).
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- pix_val  input  1  pixel valid.
- pix_rdy  output  1  loader accepts a pixel; a pixel transfers when pix_val && pix_rdy.
- pix_data  input  IMG_D*DATA_WIDTH  one pixel, all channels; channel c is at bits [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH].
- img_wren  output  FILTER_L  one-hot stripe-bank write enable; all zeros when idle.
- img_wraddr  output  IMG_RAM_ADDR_WIDTH_PER_STRIPE  per-stripe write address, shared by all banks.
- img_wrdata  output  IMG_D*DATA_WIDTH  write data; channel c goes to channel BRAM c.
- conv_val  output  1  frame loaded; start request to the convolution controller.
- conv_rdy  input  1  convolution controller is idle and accepts the start request.
- conv_last_val  input  1  convolution controller has finished the frame.
- frame_loaded  output  1  one-cycle pulse when the start handshake completes.

## Operation
- States:
  - LOAD (reset state): pix_rdy=1.
  - HANDOFF: conv_val=1.
  - COMPUTE: waiting for conv_last_val.
- LOAD: each accepted pixel uses the current counters.
  - w_cnt wraps at IMG_W-1, then h advances.
  - stripe_sel wraps at FILTER_L-1; on wrap, row_base += IMG_W.
  - h_cnt runs 0..IMG_H-1.
  - No divider or multiplier: stripe = stripe_sel and address = row_base + w_cnt, both maintained incrementally.
- Write port, registered: the cycle after acceptance, img_wren = 1 << stripe_sel, img_wraddr = row_base + w_cnt, img_wrdata = pix_data.
- The pixel with w_cnt=IMG_W-1 and h_cnt=IMG_H-1 is the last pixel.
  - Accepting it moves the state to HANDOFF.
  - All counters (w_cnt, h_cnt, stripe_sel, row_base) clear to 0.
- HANDOFF: hold conv_val=1 until conv_rdy=1. On that cycle, pulse frame_loaded and go to COMPUTE.
- COMPUTE: pix_rdy=0. Go to LOAD on conv_last_val=1.
  - conv_last_val outside COMPUTE is ignored.
- pix_val while pix_rdy=0 is held by the sender; no data is dropped.
- reset, including mid-frame: state=LOAD, all counters 0. Any partial frame is discarded; the next accepted pixel is (0,0).
- Reset values of outputs:
  - img_wren=0, img_wraddr=0, img_wrdata=0.
  - conv_val=0, frame_loaded=0.
  - pix_rdy=1 from the first cycle after reset.

## Timing
- Write latency: a pixel accepted at cycle t is written at cycle t+1. One pixel per cycle sustained in LOAD.
- Last pixel accepted at t:
  - its write occurs at t+1;
  - state is HANDOFF at t+1 with conv_val=1 and pix_rdy=0;
  - the earliest frame_loaded is t+1 (conv_rdy=1 at t+1).
- The BRAM contents are complete before the controller's first read, which is issued no earlier than t+2.
- conv_last_val at cycle u in COMPUTE: pix_rdy=1 at u+1.
- img_wren is never asserted outside the cycle following an accepted pixel.
- Gaps in pix_val stall the counters and produce no writes.

## Test plan
Parameters for all scenarios: IMG_W=4, IMG_H=5, FILTER_L=3, IMG_D=2, DATA_WIDTH=8, address width 3.

- Full frame, pix_val=1 continuously, pix_data=(h*4+w):
  - (w=2,h=4) → img_wren=3'b010, img_wraddr=6;
  - (w=3,h=2) → img_wren=3'b100, img_wraddr=3;
  - exactly 20 write cycles.
- Random pix_val gaps over a full frame → identical write sequence to the first scenario, with no writes during gaps.
- conv_rdy held 0 for 7 cycles after the last pixel:
  - conv_val stays 1 and pix_rdy stays 0;
  - frame_loaded pulses once, on the first conv_rdy=1 cycle.
- In COMPUTE, pix_val=1 for 10 cycles → no transfers and no writes. conv_last_val pulse → pix_rdy=1 the next cycle, and the next pixel writes wren=3'b001 at address 0.
- reset after 9 pixels → next pixel writes img_wren=3'b001, img_wraddr=0. The frame completes after 20 further pixels.
- conv_last_val asserted during LOAD → ignored; counters and state unchanged.
